// File: rtl/traffic_phase_sequencer.sv
// Two-road junction phase controller: loads the countdown timer and sequences main, side and pedestrian phases.
// Every output is registered, one edge after the flag that caused it; there is no backpressure and no flag-to-output path.
module traffic_phase_sequencer #(
  parameter int MAIN_GREEN_TENS = 3,
  parameter int SIDE_GREEN_TENS = 2,
  parameter int PED_TENS        = 1,
  parameter int ALLRED_CYCLES   = 2
) (
  input  logic       myClock,
  input  logic       reset,
  input  logic       counterNotZero,
  input  logic       counterNotFive,
  input  logic       pedRequest,
  output logic       load,
  output logic [1:0] tensValue,
  output logic [2:0] mainLight,
  output logic [2:0] sideLight,
  output logic       pedWalk,
  output logic       pedFlash,
  output logic       pedPending
);

  typedef enum logic [2:0] {
    INIT,
    MAIN_GREEN,
    MAIN_AMBER,
    ALLRED_A,
    SIDE_GREEN,
    SIDE_AMBER,
    ALLRED_B,
    PED_WALK
  } phaseT;

  localparam logic [1:0] MAIN_LOAD_TENS = 2'(MAIN_GREEN_TENS);
  localparam logic [1:0] SIDE_LOAD_TENS = 2'(SIDE_GREEN_TENS);
  localparam logic [1:0] PED_LOAD_TENS  = 2'(PED_TENS);
  localparam logic [1:0] CLEAR_LAST     = 2'(ALLRED_CYCLES - 1);

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] AMBER = 3'b010;
  localparam logic [2:0] GREEN = 3'b001;

  phaseT      state;
  logic [1:0] clearCount;
  logic       atZero;
  logic       atFive;

  // During the load cycle the timer still shows the previous phase's count, so its flags are stale.
  assign atZero = !load && !counterNotZero;
  assign atFive = !load && !counterNotFive;

  always_ff @(posedge myClock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      load       <= 1'b0;
      tensValue  <= 2'd0;
      mainLight  <= RED;
      sideLight  <= RED;
      pedWalk    <= 1'b0;
      pedFlash   <= 1'b0;
      pedPending <= 1'b0;
      clearCount <= 2'd0;
    end else begin
      load <= 1'b0;
      if (pedRequest && state != PED_WALK) pedPending <= 1'b1;

      case (state)
        INIT: begin
          state     <= MAIN_GREEN;
          load      <= 1'b1;
          tensValue <= MAIN_LOAD_TENS;
          mainLight <= GREEN;
        end
        MAIN_GREEN: begin
          if (atZero || atFive) begin
            state     <= MAIN_AMBER;
            mainLight <= AMBER;
          end
        end
        MAIN_AMBER: begin
          if (atZero) begin
            state      <= ALLRED_A;
            mainLight  <= RED;
            clearCount <= CLEAR_LAST;
          end
        end
        ALLRED_A: begin
          if (clearCount == 2'd0) begin
            state     <= SIDE_GREEN;
            load      <= 1'b1;
            tensValue <= SIDE_LOAD_TENS;
            sideLight <= GREEN;
          end else begin
            clearCount <= clearCount - 2'd1;
          end
        end
        SIDE_GREEN: begin
          if (atZero || atFive) begin
            state     <= SIDE_AMBER;
            sideLight <= AMBER;
          end
        end
        SIDE_AMBER: begin
          if (atZero) begin
            state      <= ALLRED_B;
            sideLight  <= RED;
            clearCount <= CLEAR_LAST;
          end
        end
        ALLRED_B: begin
          if (clearCount == 2'd0) begin
            load <= 1'b1;
            if (pedPending) begin
              // Clearing here overrides a request arriving on this same edge.
              state      <= PED_WALK;
              tensValue  <= PED_LOAD_TENS;
              pedWalk    <= 1'b1;
              pedPending <= 1'b0;
            end else begin
              state     <= MAIN_GREEN;
              tensValue <= MAIN_LOAD_TENS;
              mainLight <= GREEN;
            end
          end else begin
            clearCount <= clearCount - 2'd1;
          end
        end
        PED_WALK: begin
          if (atZero) begin
            state     <= MAIN_GREEN;
            load      <= 1'b1;
            tensValue <= MAIN_LOAD_TENS;
            mainLight <= GREEN;
            pedWalk   <= 1'b0;
            pedFlash  <= 1'b0;
          end else if (atFive) begin
            pedWalk  <= 1'b0;
            pedFlash <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: two instances (default and zero main-green tens) driving behavioural countdown timers.
module tb_traffic_phase_sequencer;

  localparam int P_INIT = 0, P_MG = 1, P_MA = 2, P_RA = 3, P_SG = 4, P_SA = 5, P_RB = 6, P_PED = 7;
  localparam int SIDE_T = 2, PED_T = 1, CLR = 2;
  localparam logic [11:0] RESET_VEC = 12'b0_00_100_100_000;

  logic myClock = 1'b0;
  logic reset = 1'b0;
  logic pedRequest = 1'b0;
  logic glitchZero = 1'b0;

  logic load0, walk0, flash0, pend0, nz0, nf0;
  logic load1, walk1, flash1, pend1, nz1, nf1;
  logic [1:0] tens0, tens1;
  logic [2:0] main0, side0, main1, side1;
  logic [11:0] vec0, vec1;
  int cnt0 = 0, cnt1 = 0;
  int nChecks = 0, nPass = 0;

  always #5 myClock = ~myClock;

  traffic_phase_sequencer dut0 (
    .myClock(myClock), .reset(reset), .counterNotZero(nz0), .counterNotFive(nf0),
    .pedRequest(pedRequest), .load(load0), .tensValue(tens0), .mainLight(main0),
    .sideLight(side0), .pedWalk(walk0), .pedFlash(flash0), .pedPending(pend0)
  );

  traffic_phase_sequencer #(.MAIN_GREEN_TENS(0)) dut1 (
    .myClock(myClock), .reset(reset), .counterNotZero(nz1), .counterNotFive(nf1),
    .pedRequest(pedRequest), .load(load1), .tensValue(tens1), .mainLight(main1),
    .sideLight(side1), .pedWalk(walk1), .pedFlash(flash1), .pedPending(pend1)
  );

  // Saturating countdown timers, one tick per clock.
  always @(posedge myClock or negedge reset) begin
    if (!reset) cnt0 <= 0;
    else if (load0) cnt0 <= int'(tens0) * 10;
    else if (cnt0 != 0) cnt0 <= cnt0 - 1;
  end
  always @(posedge myClock or negedge reset) begin
    if (!reset) cnt1 <= 0;
    else if (load1) cnt1 <= int'(tens1) * 10;
    else if (cnt1 != 0) cnt1 <= cnt1 - 1;
  end
  assign nz0 = (cnt0 != 0) && !glitchZero;
  assign nf0 = (cnt0 != 5);
  assign nz1 = (cnt1 != 0);
  assign nf1 = (cnt1 != 5);

  assign vec0 = {load0, tens0, main0, side0, walk0, flash0, pend0};
  assign vec1 = {load1, tens1, main1, side1, walk1, flash1, pend1};

  // Reference model: phase plus age in cycles, phase lengths from the timing rules.
  int mPhase[2], mAge[2], mTens[2], mainT[2];
  bit mPend[2];

  function automatic int greenLen(int t);
    return (t == 0) ? 2 : 10 * t - 3;
  endfunction

  function automatic int amberLen(int t);
    return (t == 0) ? 1 : 5;
  endfunction

  function automatic int durOf(int i, int ph);
    case (ph)
      P_MG:       return greenLen(mainT[i]);
      P_MA:       return amberLen(mainT[i]);
      P_SG:       return greenLen(SIDE_T);
      P_SA:       return amberLen(SIDE_T);
      P_RA, P_RB: return CLR;
      P_PED:      return greenLen(PED_T) + ((PED_T == 0) ? 0 : 5);
      default:    return 1;
    endcase
  endfunction

  function automatic int nextOf(int ph, bit pend);
    case (ph)
      P_MG:    return P_MA;
      P_MA:    return P_RA;
      P_RA:    return P_SG;
      P_SG:    return P_SA;
      P_SA:    return P_RB;
      P_RB:    return pend ? P_PED : P_MG;
      default: return P_MG;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mPhase[i] = P_INIT;
      mAge[i]   = 0;
      mTens[i]  = 0;
      mPend[i]  = 1'b0;
    end
  endtask

  task automatic modelStep(int i, bit ped);
    bit newPend;
    int np;
    newPend = mPend[i] | (ped && mPhase[i] != P_PED);
    np = -1;
    if (mPhase[i] == P_INIT) np = P_MG;
    else if (mAge[i] + 1 >= durOf(i, mPhase[i])) np = nextOf(mPhase[i], mPend[i]);
    if (np < 0) begin
      mAge[i]++;
    end else begin
      mPhase[i] = np;
      mAge[i]   = 0;
      if (np == P_MG) mTens[i] = mainT[i];
      else if (np == P_SG) mTens[i] = SIDE_T;
      else if (np == P_PED) begin
        mTens[i] = PED_T;
        newPend  = 1'b0;
      end
    end
    mPend[i] = newPend;
  endtask

  function automatic logic [11:0] expVec(int i);
    logic ld, wk, fl;
    logic [2:0] mn, sd;
    int ph, ag;
    ph = mPhase[i];
    ag = mAge[i];
    ld = (ph == P_MG || ph == P_SG || ph == P_PED) && ag == 0;
    mn = (ph == P_MG) ? 3'b001 : (ph == P_MA) ? 3'b010 : 3'b100;
    sd = (ph == P_SG) ? 3'b001 : (ph == P_SA) ? 3'b010 : 3'b100;
    wk = (ph == P_PED) && ag < greenLen(PED_T);
    fl = (ph == P_PED) && ag >= greenLen(PED_T);
    return {ld, 2'(mTens[i]), mn, sd, wk, fl, mPend[i]};
  endfunction

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    bit p;
    p = pedRequest;
    @(posedge myClock);
    if (reset) begin
      modelStep(0, p);
      modelStep(1, p);
    end
    #1;
    chk("model0", vec0, expVec(0));
    chk("model1", vec1, expVec(1));
  endtask

  task automatic pulseReset(int holdCycles);
    reset = 1'b0;
    #1;
    modelReset();
    chk("resetAsync0", vec0, RESET_VEC);
    chk("resetAsync1", vec1, RESET_VEC);
    repeat (holdCycles) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    int         cyc;
    logic       ped;
    logic [2:0] mainL;
    logic [2:0] sideL;
    logic       ld;
    logic [1:0] tens;
    logic       walk;
    logic       flash;
    logic       pend;
  } vecT;

  function automatic vecT mk(int cyc, logic ped, logic [2:0] mn, logic [2:0] sd, logic ld,
                             logic [1:0] tn, logic wk, logic fl, logic pd);
    vecT v;
    v.cyc = cyc; v.ped = ped; v.mainL = mn; v.sideL = sd; v.ld = ld;
    v.tens = tn; v.walk = wk; v.flash = fl; v.pend = pd;
    return v;
  endfunction

  vecT vecs[22];
  logic [2:0] d1Main[6], d1Side[6];

  initial begin
    int vi, guard, mode;
    mainT[0] = 3;
    mainT[1] = 0;
    modelReset();

    vecs[0]  = mk(1,  1'b0, 3'b001, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(2,  1'b0, 3'b001, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(10, 1'b1, 3'b001, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(27, 1'b0, 3'b001, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    vecs[4]  = mk(28, 1'b0, 3'b010, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    vecs[5]  = mk(32, 1'b0, 3'b010, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(33, 1'b0, 3'b100, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(34, 1'b0, 3'b100, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mk(35, 1'b0, 3'b100, 3'b001, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(36, 1'b0, 3'b100, 3'b001, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    vecs[10] = mk(51, 1'b0, 3'b100, 3'b001, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(52, 1'b0, 3'b100, 3'b010, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    vecs[12] = mk(56, 1'b0, 3'b100, 3'b010, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    vecs[13] = mk(57, 1'b0, 3'b100, 3'b100, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    vecs[14] = mk(58, 1'b0, 3'b100, 3'b100, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    vecs[15] = mk(59, 1'b0, 3'b100, 3'b100, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    vecs[16] = mk(60, 1'b0, 3'b100, 3'b100, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    vecs[17] = mk(65, 1'b0, 3'b100, 3'b100, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    vecs[18] = mk(66, 1'b0, 3'b100, 3'b100, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    vecs[19] = mk(70, 1'b0, 3'b100, 3'b100, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    vecs[20] = mk(71, 1'b0, 3'b001, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[21] = mk(72, 1'b0, 3'b001, 3'b100, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);

    d1Main[0] = 3'b001; d1Main[1] = 3'b001; d1Main[2] = 3'b010;
    d1Main[3] = 3'b100; d1Main[4] = 3'b100; d1Main[5] = 3'b100;
    d1Side[0] = 3'b100; d1Side[1] = 3'b100; d1Side[2] = 3'b100;
    d1Side[3] = 3'b100; d1Side[4] = 3'b100; d1Side[5] = 3'b001;

    // Reset state held over several edges, then the default sequence with one pedestrian pulse.
    repeat (3) tick();
    chk("resetHeld0", vec0, RESET_VEC);
    reset = 1'b1;
    vi = 0;
    for (int c = 1; c <= 72; c++) begin
      pedRequest = (vi < 22 && vecs[vi].cyc == c) ? vecs[vi].ped : 1'b0;
      tick();
      if (c <= 6) begin
        chk($sformatf("zeroTensMain@%0d", c), 12'(main1), 12'(d1Main[c-1]));
        chk($sformatf("zeroTensSide@%0d", c), 12'(side1), 12'(d1Side[c-1]));
      end
      if (vi < 22 && vecs[vi].cyc == c) begin
        chk($sformatf("vec@%0d", c), vec0, {vecs[vi].ld, vecs[vi].tens, vecs[vi].mainL,
            vecs[vi].sideL, vecs[vi].walk, vecs[vi].flash, vecs[vi].pend});
        vi++;
      end
    end

    // Request held through a whole walk phase stays masked until the first MAIN_GREEN edge.
    pedRequest = 1'b1;
    guard = 0;
    while (walk0 !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reachPedWalk", 12'(walk0), 12'd1);
    guard = 0;
    while ((walk0 || flash0) && guard < 40) begin
      chk("pendMaskedInPed", 12'(pend0), 12'd0);
      tick();
      guard++;
    end
    chk("pendAtMainEntry", {7'd0, load0, main0, pend0}, {7'd0, 1'b1, 3'b001, 1'b0});
    tick();
    chk("pendSetAfterEntry", 12'(pend0), 12'd1);
    pedRequest = 1'b0;

    // Asynchronous reset in the middle of SIDE_AMBER.
    guard = 0;
    while (!(mPhase[0] == P_SA && mAge[0] == 2) && guard < 200) begin
      tick();
      guard++;
    end
    chk("reachSideAmber", 12'(side0), 12'b010);
    pulseReset(2);

    // Zero flag forced during the load cycle must not end the green.
    tick();
    chk("loadAfterRelease", {6'd0, load0, tens0, main0}, {6'd0, 1'b1, 2'd3, 3'b001});
    glitchZero = 1'b1;
    tick();
    glitchZero = 1'b0;
    chk("glitchIgnored", {8'd0, load0, main0}, {8'd0, 1'b0, 3'b001});

    // Asynchronous reset while load is high.
    guard = 0;
    while (load0 !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("reachLoad", 12'(load0), 12'd1);
    pulseReset(1);
    tick();
    chk("restartLoad", {6'd0, load0, tens0, main0}, {6'd0, 1'b1, 2'd3, 3'b001});

    // Randomised request patterns with occasional mid-cycle resets.
    mode = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       pedRequest = 1'b0;
        1:       pedRequest = ($urandom_range(0, 14) == 0);
        default: pedRequest = 1'b1;
      endcase
      tick();
      if ($urandom_range(0, 499) == 0) pulseReset($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Master phase controller for the two-road junction. It drives the countdown timer's load interface (`load`, `tensValue`) and consumes its status flags (`counterNotZero`, `counterNotFive`) to sequence main-road, side-road and pedestrian phases. It produces the lamp drive outputs. The countdown timer is assumed to decrement once per `myClock` edge.

## Interface
- `MAIN_GREEN_TENS`, default 3: tens value loaded for the main-road green+amber phase (0–3).
- `SIDE_GREEN_TENS`, default 2: tens value loaded for the side-road green+amber phase (0–3).
- `PED_TENS`, default 1: tens value loaded for the pedestrian walk phase (0–3).
- `ALLRED_CYCLES`, default 2: all-red clearance length in clocks (1–3).
- `myClock` input 1: clock. All state changes occur on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `counterNotZero` input 1: from the countdown timer; low when the count is 00.
- `counterNotFive` input 1: from the countdown timer; low when the count is 05.
- `pedRequest` input 1: pedestrian button, level. It is sampled every clock.
- `load` output 1: registered single-cycle load pulse to the countdown timer.
- `tensValue` output 2: registered tens value presented with `load`. It is held until the next load.
- `mainLight` output 3: one-hot {red, amber, green}.
- `sideLight` output 3: one-hot {red, amber, green}.
- `pedWalk` output 1: walk lamp.
- `pedFlash` output 1: flashing-walk lamp, indicating the last five counts.
- `pedPending` output 1: latched pedestrian request, used for the "wait" indicator.

## Operation
- States: INIT, MAIN_GREEN, MAIN_AMBER, ALLRED_A, SIDE_GREEN, SIDE_AMBER, ALLRED_B, PED_WALK.
- Reset values: state=INIT, `load`=0, `tensValue`=0, `mainLight`=`sideLight`=3'b100, `pedWalk`=`pedFlash`=0, `pedPending`=0, clearance count=0.
- INIT always goes to MAIN_GREEN on the first edge after `reset` deasserts.
- Entry into a timed state (MAIN_GREEN, SIDE_GREEN, PED_WALK):
  - `load`=1 for exactly one cycle.
  - `tensValue` is set to that state's parameter on the same edge.
  - The status flags are ignored on the edge that ends the load cycle.
  - From the following edge on, the flags are evaluated every edge.
- MAIN_GREEN → MAIN_AMBER when `counterNotFive`=0 or `counterNotZero`=0. MAIN_AMBER and SIDE_AMBER do not reload the counter.
- MAIN_AMBER → ALLRED_A when `counterNotZero`=0.
- ALLRED_A → SIDE_GREEN after `ALLRED_CYCLES` clocks. SIDE_GREEN and SIDE_AMBER mirror the main-road states.
- SIDE_AMBER → ALLRED_B when `counterNotZero`=0.
- ALLRED_B after `ALLRED_CYCLES` clocks:
  - goes to PED_WALK if `pedPending`=1;
  - otherwise goes to MAIN_GREEN.
- PED_WALK:
  - `pedWalk`=1 until `counterNotFive`=0 is seen (or `counterNotZero`=0 is seen).
  - Then `pedWalk`=0 and `pedFlash`=1.
  - Goes to MAIN_GREEN when `counterNotZero`=0.
- Lamps per state:
  - Road lamps are red in every state except the corresponding GREEN/AMBER states.
  - Both roads are red in ALLRED and PED_WALK.
- `pedPending`:
  - Set on any edge where `pedRequest`=1 and the state is not PED_WALK.
  - Cleared on the edge entering PED_WALK. The set takes priority except on that edge.
  - `pedRequest` is masked during PED_WALK.
- Tens parameter = 0: the counter loads 00, so green lasts 2 cycles and amber lasts 1 cycle. This is legal and needs no special case.

## Timing
- All outputs are registered; there is no combinational path from the flags to the outputs.
- With a countdown timer ticking once per clock and tens value T ≥ 1:
  - green lasts 10·T−3 cycles;
  - amber lasts 5 cycles;
  - PED_WALK has `pedWalk` for 10·T−3 cycles, then `pedFlash` for 5 cycles.
- The state change occurs one edge after the timer reaches 05 or 00.
- All-red lasts exactly `ALLRED_CYCLES` cycles.
- Asynchronous reset mid-phase immediately forces the reset values.
  - If it occurs during the `load` cycle, `load` drops at once.
- Simultaneous `counterNotFive`=0 and `counterNotZero`=0 cannot happen. If seen, the state treats it as zero: green goes to amber.

## Test plan
- Reset release with a behavioural countdown model and default parameters:
  - `load`=1 and `tensValue`=3 one cycle after release;
  - `mainLight`=001 for 27 cycles, then 010 for 5 cycles;
  - then all-red for 2 cycles;
  - then `sideLight`=001 with `tensValue`=2 for 17 cycles.
- Single-cycle `pedRequest` pulse during MAIN_GREEN:
  - `pedPending`=1 through the side phase;
  - after ALLRED_B, PED_WALK starts with `tensValue`=1;
  - `pedWalk`=1 for 7 cycles, then `pedFlash`=1 for 5 cycles;
  - `pedPending`=0 from PED_WALK entry; the sequence then returns to MAIN_GREEN.
- `pedRequest` held high during PED_WALK → `pedPending` stays 0 until MAIN_GREEN entry, then sets.
- `MAIN_GREEN_TENS`=0 → green for 2 cycles, amber for 1 cycle, then ALLRED_A.
- `reset` asserted mid-SIDE_AMBER and during a `load` cycle → all outputs take reset values asynchronously. After release, the sequence restarts with MAIN_GREEN `load`.
- Flag glitch check: force `counterNotZero`=0 during the load cycle only → it is ignored and the state is unchanged.
